tone_sequencer: RTL and testbench

Parametrised multi-sound square-wave note sequencer; successor to the single-table song player. On a start request it walks the note table of the selected sound, one note at a time, through an external combinational note-table interface. For each note it generates a square wave of programmable half-period for a programmable duration. Adds rests, loop mode, stop and retrigger, a busy/done handshake and amplifier shutdown control; sits between the game/control logic and the PWM audio pin.

---
 rtl/tone_sequencer.sv | 136 +++++++++++++
 tb/tb_tone_sequencer.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tone_sequencer.sv
// Multi-sound square-wave note sequencer: walks a sound's note table through an
// external combinational lookup, playing each note as a tone or rest.
module tone_sequencer #(
  parameter int CLK_FREQ        = 50_000_000,
  parameter int TICK_DIV        = 16,
  parameter int NUM_SOUNDS      = 4,
  parameter int NOTES_PER_SOUND = 4,
  parameter int PERIOD_W        = 20,
  parameter int DUR_W           = 5,
  localparam int SEL_W = (NUM_SOUNDS > 1) ? $clog2(NUM_SOUNDS) : 1,
  localparam int IDX_W = (NOTES_PER_SOUND > 1) ? $clog2(NOTES_PER_SOUND) : 1
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                start,
  input  logic [SEL_W-1:0]    sound_sel,
  input  logic                loop_en,
  input  logic                stop,
  output logic [SEL_W-1:0]    sound_idx,
  output logic [IDX_W-1:0]    note_idx,
  input  logic [PERIOD_W-1:0] note_period,
  input  logic [DUR_W-1:0]    note_dur,
  input  logic                note_last,
  output logic                audio_out,
  output logic                aud_sd,
  output logic                busy,
  output logic                done
);

  localparam int CYC_PER_UNIT = CLK_FREQ / TICK_DIV;
  localparam int CNT_W        = DUR_W + $clog2(CYC_PER_UNIT) + 1;

  if ((CLK_FREQ % TICK_DIV) != 0 || CYC_PER_UNIT < 1) begin : g_bad_cfg
    $error("tone_sequencer: CLK_FREQ must be a nonzero exact multiple of TICK_DIV");
  end

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] PLAY = 2'd2;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NOTES_PER_SOUND - 1);

  logic [1:0]          state;
  logic [PERIOD_W-1:0] period_q;
  logic                last_q;
  logic [CNT_W-1:0]    note_cyc;
  logic [CNT_W-1:0]    time_cnt;
  logic [PERIOD_W-1:0] tone_cnt;

  assign aud_sd = busy;

  // NOTE: non-blocking assignments keep every register update edge-ordered,
  // so later statements in this block override earlier ones cleanly.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      sound_idx <= '0;
      note_idx  <= '0;
      period_q  <= '0;
      last_q    <= 1'b0;
      note_cyc  <= '0;
      time_cnt  <= '0;
      tone_cnt  <= '0;
      audio_out <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (stop) begin
        state     <= IDLE;
        busy      <= 1'b0;
        audio_out <= 1'b0;
      end else if (start) begin
        sound_idx <= sound_sel;
        note_idx  <= '0;
        state     <= LOAD;
        busy      <= 1'b1;
        audio_out <= 1'b0;
      end else begin
        case (state)
          LOAD: begin
            period_q  <= note_period;
            last_q    <= note_last;
            note_cyc  <= CNT_W'(note_dur) * CNT_W'(CYC_PER_UNIT);
            tone_cnt  <= '0;
            time_cnt  <= '0;
            audio_out <= 1'b0;
            if (note_dur == '0) begin
              // End marker: finish or loop without a PLAY phase.
              if (loop_en) begin
                note_idx <= '0;
                state    <= LOAD;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end else begin
              state <= PLAY;
            end
          end
          PLAY: begin
            time_cnt <= time_cnt + CNT_W'(1);
            if (period_q != '0) begin
              if (tone_cnt == period_q - PERIOD_W'(1)) begin
                audio_out <= ~audio_out;
                tone_cnt  <= '0;
              end else begin
                tone_cnt <= tone_cnt + PERIOD_W'(1);
              end
            end else begin
              audio_out <= 1'b0;
            end
            if (time_cnt == note_cyc - CNT_W'(1)) begin
              // Each note boundary re-enters LOAD with the line silenced.
              audio_out <= 1'b0;
              if (!last_q && note_idx < LAST_IDX) begin
                note_idx <= note_idx + IDX_W'(1);
                state    <= LOAD;
              end else if (loop_en) begin
                note_idx <= '0;
                state    <= LOAD;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tone_sequencer.sv
// Self-checking bench for tone_sequencer: a note-level reference model expands
// each sound into an expected per-cycle trace that the DUT outputs must follow.
module tb_tone_sequencer;

  localparam int NOTES = 4;
  localparam int CPU   = 100;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start, loop_en, stop;
  logic [1:0]  sound_sel, sound_idx, note_idx;
  logic [19:0] note_period;
  logic [4:0]  note_dur;
  logic        note_last, audio_out, aud_sd, busy, done;

  int tbl_per  [4][4];
  int tbl_dur  [4][4];
  bit tbl_last [4][4];

  assign note_period = 20'(tbl_per[sound_idx][note_idx]);
  assign note_dur    = 5'(tbl_dur[sound_idx][note_idx]);
  assign note_last   = tbl_last[sound_idx][note_idx];

  tone_sequencer #(
    .CLK_FREQ(1600), .TICK_DIV(16), .NUM_SOUNDS(4),
    .NOTES_PER_SOUND(NOTES), .PERIOD_W(20), .DUR_W(5)
  ) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .sound_sel(sound_sel),
    .loop_en(loop_en), .stop(stop), .sound_idx(sound_idx), .note_idx(note_idx),
    .note_period(note_period), .note_dur(note_dur), .note_last(note_last),
    .audio_out(audio_out), .aud_sd(aud_sd), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  // Observed vector layout: {busy, aud_sd, done, audio_out, sound_idx, note_idx}
  typedef struct {
    logic [7:0] v;
    logic [7:0] m;
    bit         lp;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] got_q[$];
  int total = 0;
  int bad   = 0;

  function automatic logic [7:0] pack(bit b, bit d, bit a, int s, int i);
    return {b, b, d, a, 2'(s), 2'(i)};
  endfunction

  task automatic set_note(input int s, input int i, input int per, input int dur, input bit last);
    tbl_per[s][i]  = per;
    tbl_dur[s][i]  = dur;
    tbl_last[s][i] = last;
  endtask

  // Expand sound s into the expected cycle trace, starting at its first LOAD.
  // The sound loops 'restarts' times; loop_en is dropped midway through the
  // final pass's last note.
  task automatic build(input int s, input int restarts);
    int   fin, i, pass, per, cyc;
    exp_t e;
    exp_q.delete();
    fin = 0;
    while (!(tbl_dur[s][fin] == 0 || tbl_last[s][fin] || fin == NOTES - 1)) fin++;
    pass = 0;
    i    = 0;
    forever begin
      per  = tbl_per[s][i];
      cyc  = tbl_dur[s][i] * CPU;
      e.v  = pack(1, 0, 0, s, i);
      e.m  = 8'hFF;
      e.lp = !(pass == restarts && i == fin && cyc == 0);
      exp_q.push_back(e);
      for (int p = 0; p < cyc; p++) begin
        e.v  = pack(1, 0, (per == 0) ? 1'b0 : 1'((p / per) % 2), s, i);
        e.lp = !(pass == restarts && i == fin && p >= cyc / 2);
        exp_q.push_back(e);
      end
      if (i == fin) begin
        if (pass < restarts) begin
          pass++;
          i = 0;
        end else begin
          break;
        end
      end else begin
        i++;
      end
    end
    e.v  = pack(0, 1, 0, s, 0);
    e.m  = 8'hFC;
    e.lp = 1'b0;
    exp_q.push_back(e);
    e.v  = pack(0, 0, 0, s, 0);
    exp_q.push_back(e);
  endtask

  // Called at a falling edge; records one observation per expected cycle.
  task automatic run_trace(input bit issue, input int s);
    got_q.delete();
    if (issue) begin
      sound_sel = 2'(s);
      start     = 1'b1;
      @(negedge clock);
      start = 1'b0;
    end
    foreach (exp_q[n]) begin
      got_q.push_back({busy, aud_sd, done, audio_out, sound_idx, note_idx});
      loop_en = exp_q[n].lp;
      @(negedge clock);
    end
  endtask

  task automatic test_reset();
    for (int n = 0; n < 1000; n++) begin
      @(negedge clock);
      total++;
      if ({audio_out, busy, aud_sd, done, sound_idx, note_idx} !== 8'h00) begin
        bad++;
        $display("FAIL reset_idle cyc=%0d got=%b want=00000000", n,
                 {audio_out, busy, aud_sd, done, sound_idx, note_idx});
      end
    end
  endtask

  task automatic test_single_note();
    int toggles;
    set_note(1, 0, 5, 2, 1);
    build(1, 0);
    run_trace(1, 1);
    foreach (exp_q[n]) begin
      total++;
      if ((got_q[n] & exp_q[n].m) !== (exp_q[n].v & exp_q[n].m)) begin
        bad++;
        $display("FAIL single_note cyc=%0d got=%b want=%b", n + 1, got_q[n], exp_q[n].v);
      end
    end
    toggles = 0;
    for (int n = 1; n <= 201; n++) if (got_q[n][4] != got_q[n-1][4]) toggles++;
    total++;
    if (toggles !== 40) begin
      bad++;
      $display("FAIL single_toggles got=%0d want=40", toggles);
    end
    total++;
    if (got_q[201][7:5] !== 3'b001) begin
      bad++;
      $display("FAIL single_done_c202 got=%b want=001", got_q[201][7:5]);
    end
  endtask

  task automatic load_four_notes();
    set_note(2, 0, 4, 1, 0);
    set_note(2, 1, 0, 1, 0);
    set_note(2, 2, 6, 1, 0);
    set_note(2, 3, 3, 1, 0);
  endtask

  task automatic test_four_notes();
    int code, prev, loud;
    load_four_notes();
    build(2, 0);
    run_trace(1, 2);
    code = 0; prev = -1; loud = 0;
    foreach (exp_q[n]) begin
      total++;
      if ((got_q[n] & exp_q[n].m) !== (exp_q[n].v & exp_q[n].m)) begin
        bad++;
        $display("FAIL four_notes cyc=%0d got=%b want=%b", n + 1, got_q[n], exp_q[n].v);
      end
      if (got_q[n][7] && int'(got_q[n][1:0]) != prev) begin
        prev = int'(got_q[n][1:0]);
        code = code * 10 + prev + 1;
      end
      if (got_q[n][7] && got_q[n][1:0] == 2'd1 && got_q[n][4]) loud++;
    end
    total++;
    if (code !== 1234) begin
      bad++;
      $display("FAIL four_idx_seq got=%0d want=1234", code);
    end
    total++;
    if (loud !== 0) begin
      bad++;
      $display("FAIL rest_silent got=%0d want=0", loud);
    end
  endtask

  task automatic test_loop();
    int code, prev, dones;
    load_four_notes();
    build(2, 1);
    run_trace(1, 2);
    code = 0; prev = -1; dones = 0;
    foreach (exp_q[n]) begin
      total++;
      if ((got_q[n] & exp_q[n].m) !== (exp_q[n].v & exp_q[n].m)) begin
        bad++;
        $display("FAIL loop cyc=%0d got=%b want=%b", n + 1, got_q[n], exp_q[n].v);
      end
      if (got_q[n][7] && int'(got_q[n][1:0]) != prev) begin
        prev = int'(got_q[n][1:0]);
        code = code * 10 + prev + 1;
      end
      if (got_q[n][5]) dones++;
    end
    total++;
    if (code !== 12341234 || dones !== 1) begin
      bad++;
      $display("FAIL loop_seq got=%0d/%0d want=12341234/1", code, dones);
    end
  endtask

  task automatic start_and_reach_play50();
    set_note(0, 0, 7, 1, 1);
    sound_sel = 2'd0;
    start     = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (51) @(negedge clock);
    total++;
    if ({busy, audio_out} !== {1'b1, 1'((50 / 7) % 2)}) begin
      bad++;
      $display("FAIL play50_state got=%b want=%b", {busy, audio_out}, {1'b1, 1'((50 / 7) % 2)});
    end
  endtask

  task automatic test_stop();
    int seen;
    start_and_reach_play50();
    stop = 1'b1;
    @(negedge clock);
    stop = 1'b0;
    total++;
    if ({busy, aud_sd, done, audio_out} !== 4'b0000) begin
      bad++;
      $display("FAIL stop_idle got=%b want=0000", {busy, aud_sd, done, audio_out});
    end
    seen = 0;
    repeat (150) begin
      @(negedge clock);
      if (done || busy) seen++;
    end
    total++;
    if (seen !== 0) begin
      bad++;
      $display("FAIL stop_no_done got=%0d want=0", seen);
    end
  endtask

  task automatic test_retrigger();
    load_four_notes();
    build(2, 0);
    start_and_reach_play50();
    sound_sel = 2'd2;
    start     = 1'b1;
    @(negedge clock);
    start = 1'b0;
    run_trace(0, 2);
    foreach (exp_q[n]) begin
      total++;
      if ((got_q[n] & exp_q[n].m) !== (exp_q[n].v & exp_q[n].m)) begin
        bad++;
        $display("FAIL retrigger cyc=%0d got=%b want=%b", n, got_q[n], exp_q[n].v);
      end
    end
  endtask

  task automatic test_end_marker();
    int toggles;
    set_note(3, 0, 5, 0, 0);
    build(3, 0);
    run_trace(1, 3);
    toggles = 0;
    foreach (exp_q[n]) begin
      total++;
      if ((got_q[n] & exp_q[n].m) !== (exp_q[n].v & exp_q[n].m)) begin
        bad++;
        $display("FAIL end_marker cyc=%0d got=%b want=%b", n + 1, got_q[n], exp_q[n].v);
      end
      if (got_q[n][4]) toggles++;
    end
    total++;
    if (got_q[1][7:4] !== 4'b0010 || toggles !== 0) begin
      bad++;
      $display("FAIL end_marker_done got=%b/%0d want=0010/0", got_q[1][7:4], toggles);
    end
  endtask

  task automatic test_async_reset();
    set_note(1, 0, 5, 2, 1);
    sound_sel = 2'd1;
    start     = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (6) @(negedge clock);
    total++;
    if ({busy, audio_out, sound_idx} !== 4'b1101) begin
      bad++;
      $display("FAIL pre_reset got=%b want=1101", {busy, audio_out, sound_idx});
    end
    #2 reset_n = 1'b0;
    #1;
    total++;
    if ({busy, aud_sd, done, audio_out, sound_idx, note_idx} !== 8'h00) begin
      bad++;
      $display("FAIL async_reset got=%b want=00000000",
               {busy, aud_sd, done, audio_out, sound_idx, note_idx});
    end
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    total++;
    if ({busy, done, audio_out} !== 3'b000) begin
      bad++;
      $display("FAIL post_reset got=%b want=000", {busy, done, audio_out});
    end
  endtask

  task automatic test_random();
    int s, r;
    for (int t = 0; t < 6; t++) begin
      for (int a = 0; a < 4; a++)
        for (int b = 0; b < NOTES; b++)
          set_note(a, b, int'($urandom_range(0, 12)),
                   ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 2)),
                   $urandom_range(0, 3) == 0);
      s = int'($urandom_range(0, 3));
      r = int'($urandom_range(0, 1));
      build(s, r);
      run_trace(1, s);
      foreach (exp_q[n]) begin
        total++;
        if ((got_q[n] & exp_q[n].m) !== (exp_q[n].v & exp_q[n].m)) begin
          bad++;
          $display("FAIL random t=%0d cyc=%0d got=%b want=%b", t, n + 1, got_q[n], exp_q[n].v);
        end
      end
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    start     = 1'b0;
    stop      = 1'b0;
    loop_en   = 1'b0;
    sound_sel = 2'd0;
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < NOTES; b++) set_note(a, b, 0, 1, 0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    test_reset();
    test_single_note();
    test_four_notes();
    test_loop();
    test_stop();
    test_retrigger();
    test_end_marker();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
